// File: rtl/jtag_func_pkg.sv
// -----------------------------------------------------------------------------
// jtag_func_pkg
// Shared constants and types for the DCFEB JTAG function-select decoder.
//   FW       : function code width in bits
//   NFUNC    : number of one-hot FSEL lines (code 0 is NOP, 1..NFUNC-1 select)
//   DSY_CODE : code that selects daisy-chain mode instead of an FSEL line
//   NOP_CODE : code latched at reset; selects nothing
//   state_t  : USER1 scan FSM states
// -----------------------------------------------------------------------------
package jtag_func_pkg;

    localparam int          FW       = 32'sd8;
    localparam int          NFUNC    = 32'sd16;
    localparam logic [7:0]  DSY_CODE = 8'h3F;
    localparam int          NOP_CODE = 32'sd0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        SHIFTING = 2'd2
    } state_t;

endpackage : jtag_func_pkg

// File: rtl/func_onehot_dec.sv
// -----------------------------------------------------------------------------
// func_onehot_dec
// Combinational decode of a latched function code into one-hot select lines.
// Shared with the DAQ-side decoder, so it carries no state of its own.
// Ports:
//   func      in  fw     latched function code
//   sel2      in  1      USER2 instruction active; qualifies every output
//   fsel      out nfunc  one-hot select, fsel[code] for 1 <= code < nfunc
//   dsy_chain out 1      daisy-chain mode when func == dsy_code
// Code 0 (NOP), codes >= nfunc and dsy_code never raise an fsel line.
// -----------------------------------------------------------------------------
module func_onehot_dec
    import jtag_func_pkg::*;
#(
    parameter int             fw       = FW,
    parameter int             nfunc    = NFUNC,
    parameter logic [fw-1:0]  dsy_code = fw'(DSY_CODE)
) (
    input  logic [fw-1:0]     func,
    input  logic              sel2,
    output logic [nfunc-1:0]  fsel,
    output logic              dsy_chain
);

    // Code 0 is NOP: its select line is tied low.
    assign fsel[0] = 1'b0;

    // One comparator per select line. A line whose index cannot be expressed
    // in fw bits, or which collides with the daisy-chain code, is tied low so
    // dsy_code always wins over a plain FSEL line.
    for (genvar i = 1; i < nfunc; i++) begin : g_fsel
        if ((i >= (32'sd1 << fw)) || (i == int'(dsy_code))) begin : g_tied
            assign fsel[i] = 1'b0;
        end else begin : g_cmp
            assign fsel[i] = sel2 & (func == fw'(i));
        end
    end

    // Daisy-chain mode is a dedicated line, also qualified by USER2.
    assign dsy_chain = sel2 & (func == dsy_code);

endmodule : func_onehot_dec

// File: rtl/jtag_func_dec.sv
// -----------------------------------------------------------------------------
// jtag_func_dec
// JTAG function-select decoder for the DCFEB user-register chain.
// A function code is shifted in LSB first over the USER1 data register while
// the previously latched code shifts out on TDO1. On Update-DR the bit count
// is checked: exactly fw shifts latch the new code and pulse UPD_STRB, any
// other count leaves the code alone and sets the sticky LEN_ERR flag.
// The latched code is decoded (qualified by SEL2) into FSEL / DSY_CHAIN for
// the USER2 serial-in/parallel-out write registers.
// Ports:
//   TCK       in  1      JTAG clock, all state on posedge
//   RST_N     in  1      asynchronous active-low reset
//   SEL1      in  1      USER1 instruction active (function register)
//   SEL2      in  1      USER2 instruction active (data registers)
//   TDI       in  1      serial data in
//   CAPTURE   in  1      Capture-DR
//   SHIFT     in  1      Shift-DR
//   UPDATE    in  1      Update-DR
//   FSEL      out nfunc  one-hot function select, qualified by SEL2
//   DSY_CHAIN out 1      daisy-chain mode, qualified by SEL2
//   FUNC      out fw     latched function code
//   UPD_STRB  out 1      one-cycle pulse after a code is accepted
//   LEN_ERR   out 1      sticky: last rejected update had a wrong bit count
//   TDO1      out 1      USER1 serial out (shift register LSB)
// -----------------------------------------------------------------------------
module jtag_func_dec
    import jtag_func_pkg::*;
#(
    parameter int             fw       = FW,
    parameter int             nfunc    = NFUNC,
    parameter logic [fw-1:0]  dsy_code = fw'(DSY_CODE)
) (
    input  logic              TCK,
    input  logic              RST_N,
    input  logic              SEL1,
    input  logic              SEL2,
    input  logic              TDI,
    input  logic              CAPTURE,
    input  logic              SHIFT,
    input  logic              UPDATE,
    output logic [nfunc-1:0]  FSEL,
    output logic              DSY_CHAIN,
    output logic [fw-1:0]     FUNC,
    output logic              UPD_STRB,
    output logic              LEN_ERR,
    output logic              TDO1
);

    // Bit count that makes a scan valid, held at counter width.
    localparam logic [fw:0] CNT_FULL = (fw + 1)'(fw);
    localparam logic [fw:0] CNT_MAX  = {(fw + 1){1'b1}};

    state_t         state_r;
    logic [fw-1:0]  sr_r;
    logic [fw:0]    cnt_r;
    logic [fw-1:0]  func_r;
    logic           upd_strb_r;
    logic           len_err_r;

    // Saturating increment: an over-long scan must never wrap back to fw
    // and be mistaken for a correctly sized one.
    function automatic logic [fw:0] sat_inc(input logic [fw:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + (fw + 1)'(1);
        end
    endfunction

    // USER1 scan FSM with shift register, bit counter and output registers.
    // Priority: SEL1 low aborts, then CAPTURE restarts, then UPDATE ends the
    // scan (so a stray SHIFT alongside UPDATE is ignored), then SHIFT.
    always_ff @(posedge TCK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= IDLE;
            sr_r       <= '0;
            cnt_r      <= '0;
            func_r     <= fw'(NOP_CODE);
            upd_strb_r <= 1'b0;
            len_err_r  <= 1'b0;
        end else begin
            upd_strb_r <= 1'b0;
            if (!SEL1) begin
                // Leaving USER1 mid-scan drops the scan without an update.
                state_r <= IDLE;
            end else if (CAPTURE) begin
                // Preload the current code so it shifts out on TDO1.
                state_r <= ARMED;
                sr_r    <= func_r;
                cnt_r   <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    ARMED, SHIFTING: begin
                        if (UPDATE) begin
                            state_r <= IDLE;
                            if (cnt_r == CNT_FULL) begin
                                func_r     <= sr_r;
                                upd_strb_r <= 1'b1;
                                len_err_r  <= 1'b0;
                            end else begin
                                len_err_r  <= 1'b1;
                            end
                        end else if (SHIFT) begin
                            state_r <= SHIFTING;
                            sr_r    <= {TDI, sr_r[fw-1:1]};
                            cnt_r   <= sat_inc(cnt_r);
                        end else begin
                            state_r <= state_r;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign FUNC     = func_r;
    assign UPD_STRB = upd_strb_r;
    assign LEN_ERR  = len_err_r;
    assign TDO1     = sr_r[0];

    func_onehot_dec #(
        .fw       (fw),
        .nfunc    (nfunc),
        .dsy_code (dsy_code)
    ) u_dec (
        .func      (func_r),
        .sel2      (SEL2),
        .fsel      (FSEL),
        .dsy_chain (DSY_CHAIN)
    );

endmodule : jtag_func_dec

// File: tb/tb_jtag_func_dec.sv
// -----------------------------------------------------------------------------
// tb_jtag_func_dec
// Directed bench for jtag_func_dec. Expected values come from a small model
// of the latched code / error flag and are queued when stimulus is driven,
// then popped and compared when the DUT output is sampled (#1 after posedge).
// -----------------------------------------------------------------------------
module tb_jtag_func_dec;

    logic         TCK;
    logic         RST_N;
    logic         SEL1;
    logic         SEL2;
    logic         TDI;
    logic         CAPTURE;
    logic         SHIFT;
    logic         UPDATE;
    logic [15:0]  FSEL;
    logic         DSY_CHAIN;
    logic [7:0]   FUNC;
    logic         UPD_STRB;
    logic         LEN_ERR;
    logic         TDO1;

    int           n_assert;
    int           n_fail;

    string        tag_q[$];
    logic [31:0]  val_q[$];

    logic [7:0]   m_func;
    logic         m_len;

    jtag_func_dec dut (
        .TCK       (TCK),
        .RST_N     (RST_N),
        .SEL1      (SEL1),
        .SEL2      (SEL2),
        .TDI       (TDI),
        .CAPTURE   (CAPTURE),
        .SHIFT     (SHIFT),
        .UPDATE    (UPDATE),
        .FSEL      (FSEL),
        .DSY_CHAIN (DSY_CHAIN),
        .FUNC      (FUNC),
        .UPD_STRB  (UPD_STRB),
        .LEN_ERR   (LEN_ERR),
        .TDO1      (TDO1)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        val_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_assert++;
        if (val_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h expected none", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    function automatic logic [31:0] fsel_model(input logic [7:0] f, input logic s2);
        logic [31:0] r;
        r = 32'd0;
        if (s2 && (f >= 8'd1) && (f < 8'd16) && (f != 8'h3F)) begin
            r = 32'd1 << f;
        end
        return r;
    endfunction

    task automatic check_decode();
        push("fsel", fsel_model(m_func, SEL2));
        push("dsy_chain", {31'd0, (SEL2 && (m_func == 8'h3F))});
        check(32'(FSEL));
        check(32'(DSY_CHAIN));
    endtask

    // Full USER1 scan: capture, nshift shifts of code (LSB first), update.
    task automatic scan(input logic [7:0] code, input int nshift);
        logic [7:0] old_f;
        logic       exp_strb;
        old_f   = m_func;
        SEL1    = 1'b1;
        CAPTURE = 1'b1;
        tick();
        CAPTURE = 1'b0;
        for (int i = 0; i < nshift; i++) begin
            SHIFT = 1'b1;
            TDI   = code[i % 8];
            push("tdo1", {31'd0, old_f[i % 8]});
            check(32'(TDO1));
            tick();
        end
        SHIFT  = 1'b0;
        TDI    = 1'b0;
        UPDATE = 1'b1;
        if (nshift == 8) begin
            m_func   = code;
            m_len    = 1'b0;
            exp_strb = 1'b1;
        end else begin
            m_len    = 1'b1;
            exp_strb = 1'b0;
        end
        push("func", 32'(m_func));
        push("upd_strb", {31'd0, exp_strb});
        push("len_err", {31'd0, m_len});
        tick();
        UPDATE = 1'b0;
        check(32'(FUNC));
        check(32'(UPD_STRB));
        check(32'(LEN_ERR));
        push("upd_strb_drop", 32'd0);
        tick();
        check(32'(UPD_STRB));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        m_func   = 8'd0;
        m_len    = 1'b0;
        RST_N    = 1'b0;
        SEL1     = 1'b0;
        SEL2     = 1'b0;
        TDI      = 1'b0;
        CAPTURE  = 1'b0;
        SHIFT    = 1'b0;
        UPDATE   = 1'b0;
        tick();
        tick();

        // Reset state
        push("rst_func", 32'd0);     check(32'(FUNC));
        push("rst_strb", 32'd0);     check(32'(UPD_STRB));
        push("rst_len", 32'd0);      check(32'(LEN_ERR));
        push("rst_tdo1", 32'd0);     check(32'(TDO1));
        #3;
        RST_N = 1'b1;
        SEL2  = 1'b1;
        tick();
        check_decode();

        // Basic scan of 5, decode with and without SEL2
        scan(8'h05, 8);
        check_decode();
        SEL2 = 1'b0;
        #1;
        check_decode();
        SEL2 = 1'b1;
        #1;

        // Daisy-chain code, then an out-of-range code
        scan(8'h3F, 8);
        check_decode();
        scan(8'h20, 8);
        check_decode();

        // Short scan rejected, then a correct one clears the error
        scan(8'h05, 8);
        scan(8'h09, 7);
        check_decode();
        scan(8'h09, 8);
        check_decode();

        // SEL1 dropped mid-scan: the following UPDATE is ignored
        SEL1    = 1'b1;
        CAPTURE = 1'b1;
        tick();
        CAPTURE = 1'b0;
        SHIFT   = 1'b1;
        TDI     = 1'b1;
        tick();
        tick();
        tick();
        SHIFT   = 1'b0;
        SEL1    = 1'b0;
        tick();
        SEL1    = 1'b1;
        UPDATE  = 1'b1;
        tick();
        UPDATE  = 1'b0;
        push("abort_func", 32'(m_func));  check(32'(FUNC));
        push("abort_len", {31'd0, m_len}); check(32'(LEN_ERR));
        push("abort_strb", 32'd0);         check(32'(UPD_STRB));

        // Readback: previous code 5 comes out on TDO1 while 0 goes in
        scan(8'h05, 8);
        scan(8'h00, 8);
        check_decode();

        // Asynchronous reset after 4 shifts of a scan
        scan(8'h1D, 8);
        scan(8'h07, 5);
        SEL1    = 1'b1;
        CAPTURE = 1'b1;
        tick();
        CAPTURE = 1'b0;
        SHIFT   = 1'b1;
        TDI     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        push("pre_rst_tdo1", 32'd1); check(32'(TDO1));
        #2;
        RST_N  = 1'b0;
        m_func = 8'd0;
        m_len  = 1'b0;
        #1;
        push("arst_func", 32'd0); check(32'(FUNC));
        push("arst_len", 32'd0);  check(32'(LEN_ERR));
        push("arst_strb", 32'd0); check(32'(UPD_STRB));
        push("arst_tdo1", 32'd0); check(32'(TDO1));
        check_decode();
        SHIFT = 1'b0;
        TDI   = 1'b0;
        #1;
        RST_N = 1'b1;
        tick();
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        push("noscan_func", 32'd0); check(32'(FUNC));
        push("noscan_len", 32'd0);  check(32'(LEN_ERR));
        push("noscan_strb", 32'd0); check(32'(UPD_STRB));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_jtag_func_dec
